// File: rtl/nn_buf_pkg.sv
// Shared definitions for the output-buffer readout path.
//   FIFO_DEPTH  - skid FIFO entries between the buffer read port and the stream
//   FIFO_CNT_W  - width of the FIFO occupancy count (0..FIFO_DEPTH)
//   WORD_WIDTH  - default result word width (Q8.8)
//   word_t      - stream word type
//   state_e     - readout controller FSM encoding
package nn_buf_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/readout_skid_fifo.sv
// Small synchronous FIFO that absorbs the buffer read latency.
// Storage and pointers are flops, so the head word comes straight from a register.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   push_i/data_i - write one word (ignored when full)
//   pop_i         - remove the head word (ignored when empty)
//   flush_i       - discard all contents; wins over push/pop
//   data_o        - head word
//   valid_o       - FIFO not empty
//   count_o       - number of stored words
module readout_skid_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != FullCnt);
  assign do_pop  = pop_i && (count_q != '0);

  // Pointers wrap explicitly so non-power-of-two depths also work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/output_readout_ctrl.sv
// Readout sequencer: streams a job of result words from the output buffer.
// Reads are only issued for words the activation unit has committed, and only
// when the skid FIFO has room for the word plus any read still in flight.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   start_i, abort_i       - job launch pulse / synchronous cancel
//   base_addr_i, length_i  - job parameters, sampled on an accepted start
//   wr_commit_i            - one pulse per result word written to the buffer
//   buf_rd_*               - buffer read port (1-cycle read latency)
//   m_valid_o/m_data_o/m_last_o/m_ready_i - result stream
//   busy_o, done_o         - job in progress / one-cycle completion pulse
module output_readout_ctrl
  import nn_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = WORD_WIDTH,
  parameter int ADDR_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  input  logic                  wr_commit_i,
  output logic                  buf_rd_en_o,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] buf_rd_data_i,
  input  logic                  buf_rd_valid_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                CW        = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     BufDepthC = CW'(BUFFER_DEPTH);
  localparam logic [FIFO_CNT_W:0] OccLimit = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         length_q, length_d;
  logic [CW-1:0]         committed_q, committed_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         sent_q, sent_d;
  logic                  inflight_q;

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W:0]   occupancy;
  logic                  fifo_valid;
  logic                  start_acc, flush, issue, push, pop;
  logic [CW-1:0]         addr_sum;

  assign start_acc = (state_q == ST_IDLE) && start_i && !abort_i;
  assign flush     = abort_i && (state_q != ST_IDLE);
  assign pop       = fifo_valid && m_ready_i;
  // Late read data after an abort (or stray data in IDLE) never enters the FIFO.
  assign push      = buf_rd_valid_i && (state_q != ST_IDLE) && !flush;

  // Words already buffered plus the one read still on its way back.
  assign occupancy = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, inflight_q};
  assign issue     = (state_q == ST_RUN) && (issued_q < committed_q)
                     && (occupancy < OccLimit) && !abort_i;

  // base + issued stays below 2*BUFFER_DEPTH, so one subtraction wraps it.
  assign addr_sum      = CW'(base_q) + issued_q;
  assign buf_rd_addr_o = ADDR_WIDTH'((addr_sum >= BufDepthC) ? addr_sum - BufDepthC : addr_sum);
  assign buf_rd_en_o   = issue;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    length_d    = length_q;
    committed_d = committed_q;
    issued_d    = issued_q;
    sent_d      = sent_q;

    if (state_q != ST_IDLE) begin
      if (issue) issued_d = issued_q + 1'b1;
      if (pop)   sent_d   = sent_q + 1'b1;
      if (wr_commit_i && (committed_q < length_q)) committed_d = committed_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          base_d      = base_addr_i;
          length_d    = length_i;
          issued_d    = '0;
          sent_d      = '0;
          // A commit in the start cycle already counts toward this job.
          committed_d = (wr_commit_i && (length_i != '0)) ? CW'(1) : '0;
          state_d     = (length_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issued_q == length_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Finish as soon as the final word handshakes, so done follows it directly.
        if ((sent_q == length_q) || (pop && (sent_q == length_q - CW'(1))))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      length_q    <= '0;
      committed_q <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      length_q    <= length_d;
      committed_q <= committed_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      inflight_q  <= issue;
    end
  end

  readout_skid_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (buf_rd_data_i),
    .pop_i  (pop),
    .flush_i(flush),
    .data_o (m_data_o),
    .valid_o(fifo_valid),
    .count_o(fifo_count)
  );

  assign m_valid_o = fifo_valid;
  assign m_last_o  = fifo_valid && (sent_q == length_q - CW'(1));
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_output_readout_ctrl.sv
// Directed testbench for output_readout_ctrl with a behavioural output buffer
// (1-cycle read latency). Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 time unit later, well before the next edge.
module tb_output_readout_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        startIn, abortIn, wrCommit, mReady;
  logic [7:0]  baseAddr;
  logic [8:0]  lengthIn;
  logic        bufRdEn;
  logic [7:0]  bufRdAddr;
  logic [15:0] rdData;
  logic        rdValid;
  logic        mValid, mLast, busy, done;
  logic [15:0] mData;

  logic [15:0] mem [256];

  int compCount = 0;
  int errCount  = 0;

  always #5 clk = ~clk;

  output_readout_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .start_i       (startIn),
    .abort_i       (abortIn),
    .base_addr_i   (baseAddr),
    .length_i      (lengthIn),
    .wr_commit_i   (wrCommit),
    .buf_rd_en_o   (bufRdEn),
    .buf_rd_addr_o (bufRdAddr),
    .buf_rd_data_i (rdData),
    .buf_rd_valid_i(rdValid),
    .m_valid_o     (mValid),
    .m_data_o      (mData),
    .m_last_o      (mLast),
    .m_ready_i     (mReady),
    .busy_o        (busy),
    .done_o        (done)
  );

  // Behavioural output buffer read port.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdValid <= 1'b0;
      rdData  <= '0;
    end else begin
      rdValid <= bufRdEn;
      rdData  <= mem[bufRdAddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] b, input logic [8:0] l,
                               input logic wc, input logic rdy, input logic ab);
    startIn  = s;
    baseAddr = b;
    lengthIn = l;
    wrCommit = wc;
    mReady   = rdy;
    abortIn  = ab;
    #1;
  endtask

  // Four-word job, commits in cycles 0..3, consumer always ready.
  // Reads in cycles 1..4, words out in cycles 3..6, done in cycle 7.
  task automatic runJob(input string tag, input logic [7:0] base);
    logic [7:0] a;
    nextCycle();
    applyStimulus(1'b1, base, 9'd4, 1'b1, 1'b1, 1'b0);
    checkOutput({tag, "_busy_c0"}, busy, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      nextCycle();
      applyStimulus(1'b0, base, 9'd4, (c <= 3), 1'b1, 1'b0);
      if (c <= 4) begin
        a = base + 8'(c - 1);
        checkOutput({tag, "_rden"}, bufRdEn, 1'b1);
        checkOutput({tag, "_addr"}, bufRdAddr, a);
      end
      if (c >= 3 && c <= 6) begin
        a = base + 8'(c - 3);
        checkOutput({tag, "_mvalid"}, mValid, 1'b1);
        checkOutput({tag, "_mdata"}, mData, mem[a]);
        checkOutput({tag, "_mlast"}, mLast, (c == 6));
      end
      checkOutput({tag, "_done"}, done, (c == 7));
      checkOutput({tag, "_busy"}, busy, (c <= 7));
    end
  endtask

  initial begin : stimulus
    int popped, issuedCnt, wordIdx;
    logic prevStall, doneSeen, ready, expEn, expValid;
    logic [15:0] prevData;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);
    mem[16] = 16'd1;
    mem[17] = 16'd2;
    mem[18] = 16'd3;
    mem[19] = 16'd4;

    rstN = 1'b0;
    applyStimulus(1'b0, 8'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    #3;
    checkOutput("rst_rden",  bufRdEn,   1'b0);
    checkOutput("rst_addr",  bufRdAddr, 8'd0);
    checkOutput("rst_mvalid", mValid,   1'b0);
    checkOutput("rst_mdata", mData,     16'd0);
    checkOutput("rst_mlast", mLast,     1'b0);
    checkOutput("rst_busy",  busy,      1'b0);
    checkOutput("rst_done",  done,      1'b0);
    nextCycle();
    rstN = 1'b1;
    nextCycle();

    $display("[TB] basic streaming");
    runJob("basic", 8'd16);

    $display("[TB] zero length and restart");
    nextCycle();
    applyStimulus(1'b1, 8'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 8'd16, 9'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("zero_done",   done,    1'b1);
    checkOutput("zero_busy",   busy,    1'b1);
    checkOutput("zero_rden",   bufRdEn, 1'b0);
    checkOutput("zero_mvalid", mValid,  1'b0);
    nextCycle();
    applyStimulus(1'b1, 8'd16, 9'd1, 1'b1, 1'b1, 1'b0);
    checkOutput("restart_ignored_busy", busy, 1'b0);
    checkOutput("restart_ignored_done", done, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 8'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("restart_busy", busy,      1'b1);
    checkOutput("restart_rden", bufRdEn,   1'b1);
    checkOutput("restart_addr", bufRdAddr, 8'd16);
    nextCycle();
    checkOutput("restart_rden_once", bufRdEn, 1'b0);
    nextCycle();
    checkOutput("restart_mvalid", mValid, 1'b1);
    checkOutput("restart_mdata",  mData,  16'd1);
    checkOutput("restart_mlast",  mLast,  1'b1);
    nextCycle();
    checkOutput("restart_done", done, 1'b1);
    nextCycle();
    checkOutput("restart_idle", busy, 1'b0);

    $display("[TB] credit stall");
    nextCycle();
    applyStimulus(1'b1, 8'd40, 9'd3, 1'b0, 1'b1, 1'b0);
    wordIdx = 0;
    for (int c = 1; c <= 17; c++) begin
      nextCycle();
      applyStimulus(1'b0, 8'd40, 9'd3, (c == 5 || c == 9 || c == 12), 1'b1, 1'b0);
      expEn    = (c == 6 || c == 10 || c == 13);
      expValid = (c == 8 || c == 12 || c == 15);
      checkOutput("stall_rden", bufRdEn, expEn);
      if (expEn) begin
        a = 8'd40 + 8'((c == 6) ? 0 : (c == 10) ? 1 : 2);
        checkOutput("stall_addr", bufRdAddr, a);
      end
      checkOutput("stall_mvalid", mValid, expValid);
      if (expValid) begin
        a = 8'd40 + 8'(wordIdx);
        checkOutput("stall_mdata", mData, mem[a]);
        checkOutput("stall_mlast", mLast, (c == 15));
        wordIdx++;
      end
      checkOutput("stall_done", done, (c == 16));
    end

    $display("[TB] wrap-around");
    runJob("wrap", 8'd254);

    $display("[TB] backpressure");
    nextCycle();
    applyStimulus(1'b1, 8'd100, 9'd8, 1'b1, 1'b1, 1'b0);
    popped    = 0;
    issuedCnt = 0;
    prevStall = 1'b0;
    prevData  = '0;
    doneSeen  = 1'b0;
    for (int c = 1; c <= 80 && !doneSeen; c++) begin
      nextCycle();
      ready = ((c % 4) == 0) || ((c % 4) == 3);
      applyStimulus(1'b0, 8'd100, 9'd8, (c <= 7), ready, 1'b0);
      if (bufRdEn) begin
        issuedCnt++;
        checkOutput("bp_occupancy_le4", (issuedCnt - popped <= 4), 1'b1);
      end
      if (mValid) begin
        a = 8'd100 + 8'(popped);
        checkOutput("bp_mdata", mData, mem[a]);
        checkOutput("bp_mlast", mLast, (popped == 7));
        if (prevStall) checkOutput("bp_stable", mData, prevData);
      end
      prevStall = mValid && !ready;
      prevData  = mData;
      if (mValid && ready) popped++;
      if (done) doneSeen = 1'b1;
    end
    checkOutput("bp_done_seen", doneSeen, 1'b1);
    checkOutput("bp_words",     popped,   32'd8);
    checkOutput("bp_reads",     issuedCnt, 32'd8);

    $display("[TB] abort mid-job");
    nextCycle();
    applyStimulus(1'b1, 8'd16, 9'd8, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      applyStimulus(1'b0, 8'd16, 9'd8, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("abort_pre_mdata", mData, 16'd2);
    nextCycle();
    applyStimulus(1'b0, 8'd16, 9'd8, 1'b1, 1'b0, 1'b1);
    checkOutput("abort_rden", bufRdEn, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 8'd16, 9'd8, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_busy",   busy,   1'b0);
    checkOutput("abort_mvalid", mValid, 1'b0);
    checkOutput("abort_done",   done,   1'b0);
    nextCycle();
    checkOutput("abort_mvalid2", mValid, 1'b0);
    checkOutput("abort_done2",   done,   1'b0);
    runJob("after_abort", 8'd16);

    $display("[TB] reset mid-job");
    nextCycle();
    applyStimulus(1'b1, 8'd16, 9'd8, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      applyStimulus(1'b0, 8'd16, 9'd8, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("midrst_pre_mvalid", mValid, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_rden",   bufRdEn,   1'b0);
    checkOutput("midrst_addr",   bufRdAddr, 8'd0);
    checkOutput("midrst_mvalid", mValid,    1'b0);
    checkOutput("midrst_mdata",  mData,     16'd0);
    checkOutput("midrst_mlast",  mLast,     1'b0);
    checkOutput("midrst_busy",   busy,      1'b0);
    checkOutput("midrst_done",   done,      1'b0);
    applyStimulus(1'b0, 8'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    rstN = 1'b1;
    nextCycle();
    checkOutput("midrst_idle", busy, 1'b0);
    runJob("after_reset", 8'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
